cam_capture_rgb444: RTL and testbench

- Receive end of the OV7670-style camera parallel interface: CAM_PCLK, CAM_VSYNC, CAM_HREF and CAM_px_data.
- Converts each RGB565 byte pair into one RGB444 pixel.
- Writes pixels sequentially into the 160x120 dual-port frame buffer through the DP_RAM write port (addr_in, data_in, regW).
- Sits between the camera pins and the frame buffer inside test_cam. Runs on the system clock clk and oversamples CAM_PCLK (clk is at least 4x pclk).

---
 rtl/cam_capture_rgb444_if.sv | 37 +++
 rtl/cam_capture_rgb444.sv | 201 ++++++++++++++++++++
 tb/tb_cam_capture_rgb444.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_rgb444_if.sv
// ---------------------------------------------------------------------------
// Interfaces for cam_capture_rgb444.
//
// cam_pins_if    : OV7670-style camera parallel bus.
//   CAM_PCLK     pixel clock; the capture block treats it as plain data
//   CAM_VSYNC    frame sync, high = vertical blanking
//   CAM_HREF     line valid, high = bytes valid
//   CAM_px_data  camera byte, changes on the pclk falling edge
//   modports: master = camera (drives), slave = capture block (receives)
//
// dp_ram_wr_if   : write port of the dual-port frame buffer.
//   DP_RAM_addr_in  write address
//   DP_RAM_data_in  RGB444 pixel {R,G,B}
//   DP_RAM_regW     one-clk write strobe
//   modports: master = capture block (drives), slave = frame buffer
// ---------------------------------------------------------------------------
interface cam_pins_if;
    logic       CAM_PCLK;
    logic       CAM_VSYNC;
    logic       CAM_HREF;
    logic [7:0] CAM_px_data;

    modport master (output CAM_PCLK, output CAM_VSYNC, output CAM_HREF, output CAM_px_data);
    modport slave  (input  CAM_PCLK, input  CAM_VSYNC, input  CAM_HREF, input  CAM_px_data);
endinterface

interface dp_ram_wr_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic [AW-1:0] DP_RAM_addr_in;
    logic [DW-1:0] DP_RAM_data_in;
    logic          DP_RAM_regW;

    modport master (output DP_RAM_addr_in, output DP_RAM_data_in, output DP_RAM_regW);
    modport slave  (input  DP_RAM_addr_in, input  DP_RAM_data_in, input  DP_RAM_regW);
endinterface

// File: rtl/cam_capture_rgb444.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb444
//
// Receives the camera parallel bus by oversampling it on clk (clk >= 4x pclk),
// packs each RGB565 byte pair into one RGB444 pixel and writes the pixels
// linearly into the TAM_LINE_PX x TAM_ROW frame buffer.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   cam         camera pins (cam_pins_if.slave)
//   ram         frame-buffer write port (dp_ram_wr_if.master)
//   frame_done  one-clk pulse when VSYNC rises at the end of a captured frame
//   overflow    sticky until the next frame start: more pixels than the
//               buffer holds arrived in this frame
//
// States:
//   IDLE       | after reset; wait for VSYNC high so a partial frame is never captured
//   WAIT_FRAME | vertical blanking; VSYNC falling starts a new frame
//   CAPTURE    | pairing HREF bytes into pixels; VSYNC rising ends the frame
// ---------------------------------------------------------------------------
module cam_capture_rgb444 #(
    parameter int TAM_LINE_PX = 160,
    parameter int TAM_ROW     = 120,
    parameter int AW          = 15,
    parameter int DW          = 12
) (
    input  logic              clk,
    input  logic              rst,
    cam_pins_if.slave         cam,
    dp_ram_wr_if.master       ram,
    output logic              frame_done,
    output logic              overflow
);

    localparam int            NUM_PIX   = TAM_LINE_PX * TAM_ROW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // All camera pins share one synchronizer so they stay mutually aligned.
    logic [10:0] sync1_q, sync2_q;
    logic        pclk_prev_q;
    logic        pclk_s, vsync_s, href_s;
    logic [7:0]  data_s;
    logic        pclk_rise;
    logic        vsync_last_q;
    logic        vsync_rise, vsync_fall;

    logic [6:0]    b1_q;         // {R[3:0], G[5:3]} from the first byte
    logic          phase_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          regw_q;
    logic          full_q;
    logic          ovf_q;
    logic          done_q;

    logic clr_frame, latch_b1, wr_px, clr_phase, done_d;
    logic [11:0] pixel;
    logic unused_px_bits;

    assign {pclk_s, vsync_s, href_s, data_s} = sync2_q;

    assign pclk_rise  = pclk_s & ~pclk_prev_q;
    // VSYNC edges are judged only at pclk_rise samples, like every other pin.
    assign vsync_rise = pclk_rise &  vsync_s & ~vsync_last_q;
    assign vsync_fall = pclk_rise & ~vsync_s &  vsync_last_q;

    assign pixel = {b1_q[6:3], b1_q[2:0], data_s[7], data_s[4:1]};
    assign unused_px_bits = ^{data_s[6:5], data_s[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pclk_prev_q  <= 1'b0;
            vsync_last_q <= 1'b0;
        end else begin
            sync1_q     <= {cam.CAM_PCLK, cam.CAM_VSYNC, cam.CAM_HREF, cam.CAM_px_data};
            sync2_q     <= sync1_q;
            pclk_prev_q <= pclk_s;
            if (pclk_rise) begin
                vsync_last_q <= vsync_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_frame = 1'b0;
        latch_b1  = 1'b0;
        wr_px     = 1'b0;
        clr_phase = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pclk_rise && vsync_s) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    clr_frame = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                // VSYNC rise takes priority over a byte on the same sample.
                if (vsync_rise) begin
                    done_d    = 1'b1;
                    clr_phase = 1'b1;
                    state_d   = WAIT_FRAME;
                end else if (pclk_rise) begin
                    if (href_s) begin
                        if (!phase_q) begin
                            latch_b1 = 1'b1;
                        end else begin
                            wr_px = 1'b1;
                        end
                    end else begin
                        // HREF low drops any unpaired byte left by an odd line.
                        clr_phase = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1_q    <= '0;
            phase_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            regw_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            regw_q <= 1'b0;
            done_q <= done_d;
            if (clr_frame) begin
                addr_q  <= '0;
                phase_q <= 1'b0;
                full_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                // Advance after the strobe; the final address holds and
                // marks the buffer full instead of wrapping.
                if (regw_q) begin
                    if (addr_q == LAST_ADDR) begin
                        full_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                if (latch_b1) begin
                    b1_q    <= {data_s[7:4], data_s[2:0]};
                    phase_q <= 1'b1;
                end
                if (wr_px) begin
                    phase_q <= 1'b0;
                    if (full_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        regw_q <= 1'b1;
                        data_q <= DW'(pixel);
                    end
                end
                if (clr_phase) begin
                    phase_q <= 1'b0;
                end
            end
        end
    end

    assign ram.DP_RAM_addr_in = addr_q;
    assign ram.DP_RAM_data_in = data_q;
    assign ram.DP_RAM_regW    = regw_q;
    assign frame_done         = done_q;
    assign overflow           = ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// ---------------------------------------------------------------------------
// Testbench for cam_capture_rgb444: drives the camera bus at clk/4 and logs
// every frame-buffer write; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cam_capture_rgb444;

    localparam int LPX  = 8;
    localparam int ROWS = 6;
    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int NPIX = LPX * ROWS;

    logic clk = 1'b0;
    logic rst;
    logic frame_done;
    logic overflow;

    always #5 clk = ~clk;

    cam_pins_if cam ();
    dp_ram_wr_if #(.AW(AW), .DW(DW)) ram ();

    cam_capture_rgb444 #(
        .TAM_LINE_PX (LPX),
        .TAM_ROW     (ROWS),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cam        (cam),
        .ram        (ram),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic [7:0]    b1;
        logic [7:0]    b2;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            done_cnt  = 0;
    int            wide_cnt  = 0;
    logic          regw_last = 1'b0;
    int            checks    = 0;
    int            errors    = 0;

    always @(negedge clk) begin
        if (ram.DP_RAM_regW === 1'b1) begin
            wr_addr.push_back(ram.DP_RAM_addr_in);
            wr_data.push_back(ram.DP_RAM_data_in);
            if (regw_last) wide_cnt++;
        end
        regw_last = (ram.DP_RAM_regW === 1'b1);
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    // One pclk period = 4 clk; pins change with the falling edge.
    task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d);
        cam.CAM_PCLK    = 1'b0;
        cam.CAM_VSYNC   = vs;
        cam.CAM_HREF    = hr;
        cam.CAM_px_data = d;
        repeat (2) @(posedge clk);
        #2;
        cam.CAM_PCLK = 1'b1;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic frame_start();
        repeat (6) pclk_cycle(1'b1, 1'b0, 8'h00);
        repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int npx, input logic [7:0] b1, input logic [7:0] b2,
                             input bit extra);
        for (int p = 0; p < npx; p++) begin
            pclk_cycle(1'b0, 1'b1, b1);
            pclk_cycle(1'b0, 1'b1, b2);
        end
        if (extra) pclk_cycle(1'b0, 1'b1, 8'hFF);
        repeat (4) pclk_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        repeat (3) pclk_cycle(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        bit seen;

        vecs[0] = '{8'h07, 8'hE0, 12'h0F0};
        vecs[1] = '{8'h00, 8'h1F, 12'h00F};
        vecs[2] = '{8'hFF, 8'h00, 12'hFE0};
        vecs[3] = '{8'hF8, 8'h00, 12'hF00};
        vecs[4] = '{8'h12, 8'h34, 12'h14A};
        vecs[5] = '{8'hAB, 8'hCD, 12'hA76};
        vecs[6] = '{8'h5A, 8'hA5, 12'h552};
        vecs[7] = '{8'h00, 8'h80, 12'h010};
        vecs[8] = '{8'h04, 8'h00, 12'h080};
        vecs[9] = '{8'h00, 8'h02, 12'h001};

        rst             = 1'b1;
        cam.CAM_PCLK    = 1'b0;
        cam.CAM_VSYNC   = 1'b0;
        cam.CAM_HREF    = 1'b0;
        cam.CAM_px_data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_regw", ram.DP_RAM_regW, 0);
        chk("rst_addr", ram.DP_RAM_addr_in, 0);
        chk("rst_data", ram.DP_RAM_data_in, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;

        // HREF activity while VSYNC is high after reset.
        clear_log();
        repeat (10) begin
            pclk_cycle(1'b1, 1'b1, 8'hF8);
            pclk_cycle(1'b1, 1'b1, 8'h00);
        end
        repeat (3) pclk_cycle(1'b1, 1'b0, 8'h00);
        chk("idle_no_write", wr_addr.size(), 0);
        chk("idle_no_done", done_cnt, 0);

        // Full frame of F8,00.
        clear_log();
        frame_start();
        repeat (ROWS) send_line(LPX, 8'hF8, 8'h00, 1'b0);
        frame_end();
        chk("full_count", wr_addr.size(), NPIX);
        for (int i = 0; i < NPIX && i < wr_addr.size(); i++) begin
            chk("full_addr", wr_addr[i], i);
            chk("full_data", wr_data[i], 12'hF00);
        end
        chk("full_done", done_cnt, 1);
        chk("full_ovf", overflow, 0);

        // Colour conversion table.
        clear_log();
        frame_start();
        foreach (vecs[i]) begin
            pclk_cycle(1'b0, 1'b1, vecs[i].b1);
            pclk_cycle(1'b0, 1'b1, vecs[i].b2);
        end
        repeat (4) pclk_cycle(1'b0, 1'b0, 8'h00);
        frame_end();
        chk("vec_count", wr_addr.size(), 10);
        for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
            chk("vec_addr", wr_addr[i], i);
            chk("vec_data", wr_data[i], vecs[i].exp);
        end
        chk("vec_done", done_cnt, 1);

        // Odd-length line followed by a normal line.
        clear_log();
        frame_start();
        send_line(LPX, 8'hF8, 8'h00, 1'b1);
        send_line(LPX, 8'h07, 8'hE0, 1'b0);
        frame_end();
        chk("odd_count", wr_addr.size(), 2 * LPX);
        for (int i = 0; i < 2 * LPX && i < wr_addr.size(); i++) begin
            chk("odd_addr", wr_addr[i], i);
            chk("odd_data", wr_data[i], (i < LPX) ? 12'hF00 : 12'h0F0);
        end

        // One line too many.
        clear_log();
        frame_start();
        repeat (ROWS) send_line(LPX, 8'h00, 8'h1F, 1'b0);
        chk("ovf_at_full", overflow, 0);
        chk("ovf_addr_hold", ram.DP_RAM_addr_in, NPIX - 1);
        chk("ovf_count_full", wr_addr.size(), NPIX);
        send_line(1, 8'hFF, 8'h00, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_no_write", wr_addr.size(), NPIX);
        chk("ovf_addr_still", ram.DP_RAM_addr_in, NPIX - 1);
        send_line(LPX - 1, 8'hFF, 8'h00, 1'b0);
        frame_end();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_done", done_cnt, 1);
        if (wr_addr.size() > 0) chk("ovf_last_addr", wr_addr[wr_addr.size()-1], NPIX - 1);
        repeat (6) pclk_cycle(1'b1, 1'b0, 8'h00);
        repeat (3) pclk_cycle(1'b0, 1'b0, 8'h00);
        chk("ovf_cleared", overflow, 0);
        chk("ovf_addr_reset", ram.DP_RAM_addr_in, 0);

        // Reset during a write strobe in the middle of a line.
        clear_log();
        repeat (3) begin
            pclk_cycle(1'b0, 1'b1, 8'h07);
            pclk_cycle(1'b0, 1'b1, 8'hE0);
        end
        pclk_cycle(1'b0, 1'b1, 8'h07);
        pclk_cycle(1'b0, 1'b1, 8'hE0);
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (ram.DP_RAM_regW === 1'b1) seen = 1'b1;
        end
        chk("pre_rst_strobe_seen", seen, 1);
        chk("pre_rst_addr", ram.DP_RAM_addr_in, 3);
        #1 rst = 1'b1;
        #1;
        chk("midrst_regw", ram.DP_RAM_regW, 0);
        chk("midrst_addr", ram.DP_RAM_addr_in, 0);
        chk("midrst_data", ram.DP_RAM_data_in, 0);
        chk("midrst_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        clear_log();
        pclk_cycle(1'b0, 1'b1, 8'h07);
        repeat (2) send_line(4, 8'h07, 8'hE0, 1'b0);
        chk("post_rst_no_write", wr_addr.size(), 0);
        frame_start();
        send_line(2, 8'h12, 8'h34, 1'b0);
        frame_end();
        chk("post_rst_count", wr_addr.size(), 2);
        if (wr_addr.size() > 0) begin
            chk("post_rst_first_addr", wr_addr[0], 0);
            chk("post_rst_first_data", wr_data[0], 12'h14A);
        end
        chk("post_rst_done", done_cnt, 1);

        chk("regw_one_clk", wide_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
